// File: rtl/tick_ctrl_pkg.sv
// Shared types and constants for the tick counter sequencing controller.
package tick_ctrl_pkg;

  localparam int TICK_WIDTH_DEFAULT = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } tick_state_e;

endpackage

// File: rtl/tick_counter_ctrl_count_next.sv
// Combinational advance rule: next count value and terminal-event flag.
import tick_ctrl_pkg::*;

module count_next #(
  parameter int WIDTH = TICK_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir_q,
  input  logic [WIDTH-1:0] lim_q,
  output logic [WIDTH-1:0] next_count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [WIDTH-1:0] start_val_s;
  logic [WIDTH-1:0] term_val_s;

  // Terminal detection precedes the step, so no modular wrap is ever relied on.
  always_comb begin
    start_val_s = ZERO_C;
    term_val_s  = lim_q;
    if (dir_q == DIR_DOWN) begin
      start_val_s = lim_q;
      term_val_s  = ZERO_C;
    end else begin
      start_val_s = ZERO_C;
      term_val_s  = lim_q;
    end
    terminal = (count == term_val_s);
    if (terminal) begin
      next_count = start_val_s;
    end else if (dir_q == DIR_DOWN) begin
      next_count = count - ONE_C;
    end else begin
      next_count = count + ONE_C;
    end
  end

endmodule

// File: rtl/tick_counter_ctrl.sv
// Tick counter sequencer: start/pause/step/stop FSM with wrap or hold at terminal.
import tick_ctrl_pkg::*;

module tick_counter_ctrl #(
  parameter int WIDTH       = TICK_WIDTH_DEFAULT,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  tick_state_e      state_r, state_nxt_s;
  logic [WIDTH-1:0] count_r, count_nxt_s;
  logic [WIDTH-1:0] lim_r, lim_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic             wrap_r, wrap_nxt_s;
  logic             running_r, done_r;
  logic             adv_s;
  logic [WIDTH-1:0] adv_val_s;
  logic             term_s;

  count_next #(.WIDTH(WIDTH)) u_count_next (
    .count      (count_r),
    .dir_q      (dir_r),
    .lim_q      (lim_r),
    .next_count (adv_val_s),
    .terminal   (term_s)
  );

  // Next-state, next-count and latch logic; stop overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    dir_nxt_s   = dir_r;
    lim_nxt_s   = lim_r;
    wrap_nxt_s  = 1'b0;
    adv_s       = 1'b0;
    if (stop) begin
      state_nxt_s = ST_IDLE;
      count_nxt_s = (dir_r == DIR_DOWN) ? lim_r : ZERO_C;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // Load from the incoming dir/limit, not the stale latched copies.
          if (start) begin
            dir_nxt_s   = dir;
            lim_nxt_s   = limit;
            count_nxt_s = (dir == DIR_DOWN) ? limit : ZERO_C;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_RUN: begin
          if (start) begin
            adv_s = tick;
          end else if (pause) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            adv_s = tick;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_nxt_s = ST_RUN;
          end else if (pause) begin
            adv_s = 1'b0;
          end else begin
            adv_s = step;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = ZERO_C;
        end
      endcase

      if (adv_s) begin
        if (term_s) begin
          wrap_nxt_s = 1'b1;
          if (AUTO_RELOAD) begin
            count_nxt_s = adv_val_s;
          end else begin
            count_nxt_s = count_r;
            state_nxt_s = ST_DONE;
          end
        end else begin
          count_nxt_s = adv_val_s;
        end
      end else begin
        wrap_nxt_s = 1'b0;
      end
    end
  end

  // State, latched settings and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= ZERO_C;
      dir_r     <= DIR_UP;
      lim_r     <= ZERO_C;
      wrap_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      dir_r     <= dir_nxt_s;
      lim_r     <= lim_nxt_s;
      wrap_r    <= wrap_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

  assign count   = count_r;
  assign running = running_r;
  assign done    = done_r;
  assign wrap    = wrap_r;

endmodule
